// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI target memory.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_TX,
    S_WAIT_CS
  } spi_slv_state_t;

  localparam int unsigned WR_ADDR_BITS  = 8;
  localparam int unsigned RD_ADDR_BITS  = 7;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned DEFAULT_DEPTH = 32;
  localparam int unsigned DEFAULT_AW    = 5;

endpackage

// File: rtl/spi_mem_array.sv
// Byte register array: async-cleared, synchronous write, combinational read.
module spi_mem_array
  import spi_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_mem_slave.sv
// SPI target memory: deserializes LSB-first command frames, writes or serializes array bytes.
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic mem_ready,
  output logic mem_done
);

  localparam logic [4:0] WrAddrLast = 5'(WR_ADDR_BITS - 1);
  localparam logic [4:0] RdAddrLast = 5'(RD_ADDR_BITS - 1);
  localparam logic [4:0] DataLast   = 5'(DATA_BITS - 1);
  localparam logic [4:0] DataBits   = 5'(DATA_BITS);

  spi_slv_state_t state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           rw_q, rw_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     tx_q, tx_d;
  logic           miso_q, miso_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic       in_range;
  logic       we;
  logic [7:0] mem_rdata;
  logic [7:0] rdata;

  assign in_range = (32'(addr_q) < DEPTH);
  // A write that is aborted on its commit edge must not reach the array.
  assign we       = (state_q == S_WRITE) && !cs && in_range;
  assign rdata    = in_range ? mem_rdata : 8'h00;

  spi_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(addr_q[AW-1:0]),
    .wdata(data_q),
    .raddr(addr_q[AW-1:0]),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    miso_d  = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!cs) state_d = S_CMD;
      end
      S_CMD: begin
        rw_d    = mosi;
        addr_d  = '0;
        data_d  = '0;
        cnt_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        addr_d[cnt_q[2:0]] = mosi;
        cnt_d = cnt_q + 5'd1;
        if (rw_q && cnt_q == WrAddrLast) begin
          cnt_d   = '0;
          state_d = S_WDATA;
        end else if (!rw_q && cnt_q == RdAddrLast) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = S_TX;
        end
      end
      S_WDATA: begin
        data_d[cnt_q[2:0]] = mosi;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DataLast) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_WAIT_CS;
      end
      S_TX: begin
        // First TX edge loads the byte addressed by the just-completed address.
        if (cnt_q == 5'd0) begin
          miso_d = rdata[0];
          tx_d   = {1'b0, rdata[7:1]};
          cnt_d  = cnt_q + 5'd1;
        end else if (cnt_q < DataBits) begin
          miso_d = tx_q[0];
          tx_d   = {1'b0, tx_q[7:1]};
          cnt_d  = cnt_q + 5'd1;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT_CS;
        end
      end
      S_WAIT_CS: begin
        if (cs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cs && state_q != S_IDLE && state_q != S_WAIT_CS) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      ready_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign miso      = miso_q;
  assign mem_ready = ready_q;
  assign mem_done  = done_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: acts as the SPI controller with a reference byte model.
module tb_spi_mem_slave;

  logic clk;
  logic rst_n;
  logic cs;
  logic mosi;
  logic miso;
  logic mem_ready;
  logic mem_done;

  int total;
  int bad;
  int rdy_cnt;
  int done_cnt;

  logic [7:0] model [32];
  logic [7:0] exp_q [$];

  spi_mem_slave #(
    .DEPTH(32),
    .AW   (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .mem_ready(mem_ready),
    .mem_done (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ready) rdy_cnt++;
    if (mem_done) done_cnt++;
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
  endtask

  // Full write frame; C0 is the posedge following the negedge that drops cs.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int d0;
    d0 = done_cnt;
    @(negedge clk); cs = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); mosi = a[i]; end
    for (int i = 0; i < 8; i++) begin @(negedge clk); mosi = d[i]; end
    @(negedge clk);
    total++;
    if (mem_done !== 1'b0) begin
      bad++; $display("FAIL wr_done_early a=%0d got=%b want=0", a, mem_done);
    end
    @(negedge clk);
    total++;
    if (mem_done !== 1'b1) begin
      bad++; $display("FAIL wr_done_c18 a=%0d got=%b want=1", a, mem_done);
    end
    cs = 1'b1;
    @(negedge clk);
    total++;
    if (mem_done !== 1'b0 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL wr_done_pulse a=%0d got=%b pulses=%0d want=0 pulses=1",
                      a, mem_done, done_cnt - d0);
    end
    if (a < 8'd32) model[a[4:0]] = d;
    @(negedge clk);
  endtask

  // Full read frame; expected byte goes into the scoreboard when the command is issued.
  task automatic do_read(input logic [7:0] a);
    logic [7:0] got;
    logic [7:0] want;
    int r0;
    r0 = rdy_cnt;
    exp_q.push_back((a < 8'd32) ? model[a[4:0]] : 8'h00);
    @(negedge clk); cs = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = 1'b0;
    for (int i = 0; i < 7; i++) begin @(negedge clk); mosi = a[i]; end
    @(negedge clk);
    total++;
    if (mem_ready !== 1'b1) begin
      bad++; $display("FAIL rd_ready_c8 a=%0d got=%b want=1", a, mem_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (mem_ready !== 1'b0) begin
          bad++; $display("FAIL rd_ready_c9 a=%0d got=%b want=0", a, mem_ready);
        end
      end
      got[i] = miso;
    end
    @(negedge clk);
    total++;
    if (miso !== 1'b0 || rdy_cnt - r0 != 1) begin
      bad++; $display("FAIL rd_end a=%0d miso=%b pulses=%0d want miso=0 pulses=1",
                      a, miso, rdy_cnt - r0);
    end
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL rd_scoreboard_empty a=%0d got=%h", a, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL rd_data a=%0d got=%h want=%h", a, got, want);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; mosi = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if (miso !== 1'b0 || mem_ready !== 1'b0 || mem_done !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b want=000", miso, mem_ready, mem_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (miso !== 1'b0 || mem_ready !== 1'b0 || mem_done !== 1'b0) begin
      bad++; $display("FAIL idle_outputs got=%b%b%b want=000", miso, mem_ready, mem_done);
    end
  endtask

  task automatic test_read_empty();
    do_read(8'd31);
  endtask

  task automatic test_write_read();
    do_write(8'd3, 8'hA5);
    do_read(8'd3);
  endtask

  task automatic test_abort();
    int d0;
    logic [7:0] a;
    logic [7:0] d;
    a = 8'd7; d = 8'h3C;
    d0 = done_cnt;
    @(negedge clk); cs = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); mosi = a[i]; end
    for (int i = 0; i < 3; i++) begin @(negedge clk); mosi = d[i]; end
    @(negedge clk); cs = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt != d0 || mem_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done pulses=%0d want=0", done_cnt - d0);
    end
    do_read(8'd7);
  endtask

  task automatic test_out_of_range();
    do_write(8'd40, 8'hFF);
    do_read(8'd8);
    do_read(8'd0);
  endtask

  task automatic test_back_to_back();
    int r0;
    int d0;
    r0 = rdy_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) do_write(8'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 32; i++) do_read(8'(i));
    total++;
    if (rdy_cnt - r0 != 32 || done_cnt - d0 != 32) begin
      bad++; $display("FAIL b2b_pulses ready=%0d done=%0d want=32/32", rdy_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] a;
    a = 8'd3;
    do_write(a, 8'hA5);
    @(negedge clk); cs = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = 1'b0;
    for (int i = 0; i < 7; i++) begin @(negedge clk); mosi = a[i]; end
    repeat (4) @(negedge clk);
    total++;
    if (miso !== 1'b1) begin
      bad++; $display("FAIL mid_bit2 got=%b want=1", miso);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (miso !== 1'b0 || mem_ready !== 1'b0 || mem_done !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b%b%b want=000", miso, mem_ready, mem_done);
    end
    cs = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(8'd3);
    do_read(8'd31);
  endtask

  initial begin
    total = 0; bad = 0; rdy_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; cs = 1'b1; mosi = 1'b0;
    test_reset();
    test_read_empty();
    test_write_read();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
